// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the fetch-PC redirect controller: state encoding and parameter defaults.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] DEF_PC_STEP  = 32'd4;
    localparam int          DEF_CNT_W    = 16;

    // A redirect target must be word aligned; anything else is diverted to the trap vector.
    function automatic logic is_misaligned(input logic [31:0] target);
        return (target[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] redirect_target(input logic [31:0] target,
                                                    input logic [31:0] trap_vec);
        return is_misaligned(target) ? trap_vec : target;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_redirect_buffer.sv
// Holds one redirect target that arrived while imem could not take a new fetch address.
// Latency: load/consume take effect at the next clock edge.
// Backpressure: none; a load overwrites the held target (newest redirect wins).
module pc_redirect_ctrl_redirect_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        consume,
    output logic [31:0] pend_pc,
    output logic        pend_vld
);

    // Load has priority over consume so a same-cycle new target is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_pc  <= 32'h0000_0000;
            pend_vld <= 1'b0;
        end else if (load) begin
            pend_pc  <= load_pc;
            pend_vld <= 1'b1;
        end else if (consume) begin
            pend_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Owns the fetch PC: sequential step, hold on stall/imem wait, EX redirects with flush and trap.
// Latency: redirect lands on pc the cycle after it is seen with imem_ready=1, else after the ready edge.
// Backpressure: imem_ready=0 holds pc; a redirect seen then is buffered until imem_ready returns.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
    parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
    parameter int          CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             br_taken,
    input  logic [31:0]      br_pc,
    output logic [31:0]      pc,
    output logic             pc_valid,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mis_q;
    logic             accept;
    logic [31:0]      tgt;
    logic             buf_load;
    logic             buf_consume;
    logic [31:0]      pend_pc;
    logic             pend_vld;

    // A redirect counts (and flushes) in any state except the post-reset BOOT cycle.
    assign accept = br_taken && (state_q != ST_BOOT);
    assign tgt    = redirect_target(br_pc, TRAP_VEC);

    pc_redirect_ctrl_redirect_buffer u_redirect_buffer (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .load_pc  (tgt),
        .consume  (buf_consume),
        .pend_pc  (pend_pc),
        .pend_vld (pend_vld)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_BOOT;
        else     state_q <= state_d;
    end

    // Next state: redirect blocked by imem parks in PENDING until imem takes an address.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:    state_d = ST_RUN;
            ST_RUN:     if (br_taken && !imem_ready) state_d = ST_PENDING;
            ST_PENDING: if (imem_ready) state_d = ST_RUN;
            default:    state_d = ST_BOOT;
        endcase
    end

    // Next-pc mux and buffer control; redirect outranks stall, stall is ignored in PENDING.
    always_comb begin
        pc_d        = pc_q;
        buf_load    = 1'b0;
        buf_consume = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (br_taken) begin
                    if (imem_ready) pc_d = tgt;
                    else            buf_load = 1'b1;
                end else if (!stall && imem_ready) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            ST_PENDING: begin
                if (imem_ready) begin
                    buf_consume = 1'b1;
                    if (br_taken)      pc_d = tgt;
                    else if (pend_vld) pc_d = pend_pc;
                end else if (br_taken) begin
                    buf_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // PC, misalign pulse and saturating redirect counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= accept && is_misaligned(br_pc);
            if (accept && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = (state_q != ST_BOOT);
    assign flush_if_id  = accept;
    assign flush_id_ex  = accept;
    assign misalign     = mis_q;
    assign redirect_cnt = cnt_q;

endmodule
